mem_responder: RTL

- Word-organised memory target answering the multicycle RV32I core's memory port: mem_read/mem_write held by the core until a one-cycle mem_resp pulse.
- Provides configurable fixed latency, byte-enabled writes, and out-of-range/protocol error flagging.
- Used as the simulation memory behind the core's MAR/MDR/data-out registers; also usable as on-chip scratch RAM.

---
 rtl/mem_responder_pkg.sv | 24 ++
 rtl/mem_array.sv | 38 +++
 rtl/mem_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_types: shared types and constants for the mem_responder block.
//   mem_resp_state_t : IDLE / WAIT / RESPOND transaction states
//   mem_op_t         : latched operation type of the transaction in flight
//   MAX_LATENCY      : largest supported LATENCY value
//   WORD_BYTES       : byte lanes per 32-bit word
//   CNT_W            : width of the latency countdown register
package mem_responder_types;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } mem_resp_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_t;

  localparam int MAX_LATENCY = 15;
  localparam int WORD_BYTES  = 4;
  localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/mem_array.sv
// mem_array: 2^ADDR_WIDTH x 32-bit word storage.
//   clk   : rising-edge clock for writes
//   we    : write enable
//   be    : byte lane enables, bit i = byte i
//   waddr : word index of the write
//   wdata : write data
//   raddr : word index of the combinational read
//   rdata : read data (combinational)
// Contents are never cleared; only written lanes change.
module mem_array
  import mem_responder_types::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) begin
          mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory target for a held-request /
// one-cycle-response memory port.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   mem_read        : read request, held until mem_resp
//   mem_write       : write request, held until mem_resp
//   mem_byte_enable : write lane enables
//   mem_address     : byte address, bits [1:0] ignored
//   mem_wdata       : write data
//   mem_rdata       : read data, valid in the mem_resp cycle, held until the next read
//   mem_resp        : one-cycle completion pulse
//   mem_error       : sticky error (out-of-range access or read+write together)
// Handshake: a request is a level held on mem_read or mem_write; the block
// answers with mem_resp high for exactly one cycle, LATENCY cycles after the
// request first appears. Dropping both requests while waiting aborts.
// Optional: define MEM_RESPONDER_STATS_EN to add saturating rd_count/wr_count
// outputs counting completed reads and writes.
// Legal parameter ranges: LATENCY 1..15, ADDR_WIDTH 1..29.
module mem_responder
  import mem_responder_types::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_error
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  mem_resp_state_t       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  mem_op_t               op_q, op_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  oor_q, oor_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic [ADDR_WIDTH-1:0] req_idx, rd_idx;
  logic                  req_oor, rd_oor;
  logic [31:0]           arr_rdata;
  logic                  arr_we;
  logic                  unused_addr_lsbs;

  assign req_idx          = mem_address[ADDR_WIDTH+1:2];
  assign req_oor          = |mem_address[31:ADDR_WIDTH+2];
  assign unused_addr_lsbs = ^mem_address[1:0];

  // With LATENCY==1 the read address is latched on the same edge that enters
  // RESPOND, so the array is read from the live address while in IDLE.
  assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;
  assign rd_oor = (state_q == IDLE) ? req_oor : oor_q;

  // Writes commit at the edge closing RESPOND; a reset on that edge discards them.
  assign arr_we = (state_q == RESPOND) && (op_q == OP_WRITE) && !oor_q && !rst;

  mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (be_q),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    error_d = error_q;

    case (state_q)
      IDLE: begin
        if (mem_read && mem_write) begin
          error_d = 1'b1;
        end else if (mem_read || mem_write) begin
          op_d    = mem_write ? OP_WRITE : OP_READ;
          idx_d   = req_idx;
          oor_d   = req_oor;
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          if (LATENCY == 1) begin
            state_d = RESPOND;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!mem_read && !mem_write) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read data and the out-of-range flag are captured on the edge entering RESPOND.
    if ((state_d == RESPOND) && (state_q != RESPOND)) begin
      if (op_d == OP_READ) begin
        rdata_d = rd_oor ? '0 : arr_rdata;
      end
      if (rd_oor) begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = (state_q == RESPOND);
  assign mem_error = error_q;

`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] rd_count_q, wr_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (state_q == RESPOND) begin
      if ((op_q == OP_READ) && (rd_count_q != '1)) rd_count_q <= rd_count_q + 1'b1;
      if ((op_q == OP_WRITE) && (wr_count_q != '1)) wr_count_q <= wr_count_q + 1'b1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule
